// File: rtl/e_mdu_ctrl.sv
// Execute-stage multiply/divide scheduler: owns HI/LO, computes the result at start and
// commits it after a fixed busy window so HI/LO-dependent instructions can stall on E_Busy.
module e_mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_MDStart,
    input  logic [3:0]  E_MDOp,
    input  logic        E_MDWrite,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_Busy,
    output logic [31:0] E_RDHI,
    output logic [31:0] E_RDLO
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] phi_q, plo_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q;

    logic        start_ok;
    logic        is_mul;
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, div_by;
    logic [31:0] q_mag, r_mag;
    logic [31:0] res_hi, res_lo;

    assign start_ok = E_MDStart && (E_MDOp >= OpMult) && (E_MDOp <= OpDivu);
    assign is_mul   = (E_MDOp == OpMult) || (E_MDOp == OpMultu);

    always_comb begin
        prod_s = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
        prod_u = {32'd0, E_A} * {32'd0, E_B};

        // Divide on magnitudes; divisor forced non-zero so no X ever reaches HI/LO.
        a_neg  = (E_MDOp == OpDiv) && E_A[31];
        b_neg  = (E_MDOp == OpDiv) && E_B[31];
        a_mag  = a_neg ? (~E_A + 32'd1) : E_A;
        b_mag  = b_neg ? (~E_B + 32'd1) : E_B;
        div_by = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / div_by;
        r_mag  = a_mag % div_by;

        res_hi = 32'd0;
        res_lo = 32'd0;
        if (E_MDOp == OpMult) begin
            {res_hi, res_lo} = prod_s;
        end else if (E_MDOp == OpMultu) begin
            {res_hi, res_lo} = prod_u;
        end else if (E_B == 32'd0) begin
            res_lo = 32'hFFFF_FFFF;
            res_hi = E_A;
        end else if ((E_MDOp == OpDiv) && (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF)) begin
            res_lo = 32'h8000_0000;
            res_hi = 32'd0;
        end else begin
            res_lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
            res_hi = a_neg ? (~r_mag + 32'd1) : r_mag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_ok) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        phi_q   <= res_hi;
                        plo_q   <= res_lo;
                        cnt_q   <= is_mul ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
                    end else if (E_MDWrite && (E_MDOp == OpMthi)) begin
                        hi_q <= E_A;
                    end else if (E_MDWrite && (E_MDOp == OpMtlo)) begin
                        lo_q <= E_A;
                    end
                end
                StRun: begin
                    if (cnt_q == 5'd1) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        hi_q    <= phi_q;
                        lo_q    <= plo_q;
                        cnt_q   <= 5'd0;
                    end else begin
                        cnt_q <= cnt_q - 5'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign E_Busy = busy_q;
    assign E_RDHI = hi_q;
    assign E_RDLO = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed self-checking bench for e_mdu_ctrl.
module tb_e_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        E_MDStart = 1'b0;
    logic [3:0]  E_MDOp = 4'd0;
    logic        E_MDWrite = 1'b0;
    logic [31:0] E_A = 32'd0;
    logic [31:0] E_B = 32'd0;
    logic        E_Busy;
    logic [31:0] E_RDHI, E_RDLO;

    int checks = 0;
    int errors = 0;

    e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_MDStart (E_MDStart),
        .E_MDOp    (E_MDOp),
        .E_MDWrite (E_MDWrite),
        .E_A       (E_A),
        .E_B       (E_B),
        .E_Busy    (E_Busy),
        .E_RDHI    (E_RDHI),
        .E_RDLO    (E_RDLO)
    );

    always #5 clk = ~clk;

    // Starts an op in the current cycle (caller sits #1 after an edge), counts busy cycles,
    // checks HI/LO hold old values during the window and carry the result afterwards.
    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic wr, input int n,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] old_hi, old_lo;
        int cnt;
        bit held;
        old_hi = E_RDHI;
        old_lo = E_RDLO;
        checks++;
        if (E_Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s start-cycle busy: got %0b want 0", name, E_Busy);
        end
        E_MDStart = 1'b1; E_MDWrite = wr; E_MDOp = op; E_A = a; E_B = b;
        @(posedge clk); #1;
        E_MDStart = 1'b0; E_MDWrite = 1'b0; E_MDOp = 4'd0;
        cnt = 0;
        held = 1'b1;
        while (E_Busy === 1'b1 && cnt < 40) begin
            if (E_RDHI !== old_hi || E_RDLO !== old_lo) held = 1'b0;
            cnt++;
            @(posedge clk); #1;
        end
        checks++;
        if (cnt != n) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want %0d", name, cnt, n);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL %s hold: HI/LO changed during busy window (old %h/%h)", name,
                     old_hi, old_lo);
        end
        checks++;
        if (E_RDHI !== exp_hi || E_RDLO !== exp_lo) begin
            errors++;
            $display("FAIL %s result: got HI=%h LO=%h want HI=%h LO=%h", name, E_RDHI,
                     E_RDLO, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (E_Busy !== 1'b0 || E_RDHI !== 32'd0 || E_RDLO !== 32'd0) begin
            errors++;
            $display("FAIL reset hold: got busy=%0b HI=%h LO=%h want 0/0/0", E_Busy, E_RDHI,
                     E_RDLO);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (E_Busy !== 1'b0 || E_RDHI !== 32'd0 || E_RDLO !== 32'd0) begin
            errors++;
            $display("FAIL reset release: got busy=%0b HI=%h LO=%h want 0/0/0", E_Busy,
                     E_RDHI, E_RDLO);
        end
    endtask

    task automatic test_mult();
        run_op("mult", 4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    endtask

    task automatic test_div();
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu0", 4'd4, 32'd7, 32'd0, 1'b0, 10, 32'd7, 32'hFFFF_FFFF);
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0, 32'h8000_0000);
        run_op("div0s", 4'd3, 32'hFFFF_FFF0, 32'd0, 1'b0, 10, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] lo_before;
        lo_before = E_RDLO;
        E_MDWrite = 1'b1; E_MDOp = 4'd5; E_A = 32'h1234_5678;
        @(posedge clk); #1;
        E_MDWrite = 1'b0; E_MDOp = 4'd0;
        checks++;
        if (E_RDHI !== 32'h1234_5678 || E_RDLO !== lo_before) begin
            errors++;
            $display("FAIL mthi: got HI=%h LO=%h want HI=12345678 LO=%h", E_RDHI, E_RDLO,
                     lo_before);
        end
        E_MDWrite = 1'b1; E_MDOp = 4'd6; E_A = 32'hCAFE_0001;
        @(posedge clk); #1;
        E_MDWrite = 1'b0; E_MDOp = 4'd0;
        checks++;
        if (E_RDHI !== 32'h1234_5678 || E_RDLO !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL mtlo: got HI=%h LO=%h want HI=12345678 LO=cafe0001", E_RDHI, E_RDLO);
        end
        // No-op codes leave HI/LO untouched.
        E_MDStart = 1'b1; E_MDWrite = 1'b1; E_MDOp = 4'd9; E_A = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        E_MDStart = 1'b0; E_MDWrite = 1'b0; E_MDOp = 4'd0;
        checks++;
        if (E_Busy !== 1'b0 || E_RDHI !== 32'h1234_5678 || E_RDLO !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL noop: got busy=%0b HI=%h LO=%h want 0/12345678/cafe0001", E_Busy,
                     E_RDHI, E_RDLO);
        end
    endtask

    task automatic test_write_during_busy();
        E_MDStart = 1'b1; E_MDOp = 4'd1; E_A = 32'd3; E_B = 32'd5;
        @(posedge clk); #1;
        E_MDStart = 1'b0;
        E_MDWrite = 1'b1; E_MDOp = 4'd6; E_A = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        E_MDWrite = 1'b0; E_MDOp = 4'd0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (E_Busy !== 1'b0 || E_RDHI !== 32'd0 || E_RDLO !== 32'd15) begin
            errors++;
            $display("FAIL mtlo_in_busy: got busy=%0b HI=%h LO=%h want 0/00000000/0000000f",
                     E_Busy, E_RDHI, E_RDLO);
        end
    endtask

    task automatic test_back_to_back();
        run_op("b2b_multu", 4'd2, 32'd3, 32'd4, 1'b0, 5, 32'd0, 32'd12);
        run_op("b2b_divu", 4'd4, 32'd100, 32'd7, 1'b0, 10, 32'd2, 32'd14);
        // Start and write together: start executes, HI is not overwritten with E_A.
        run_op("start_wr", 4'd2, 32'd2, 32'd3, 1'b1, 5, 32'd0, 32'd6);
    endtask

    task automatic test_reset_mid_div();
        E_MDStart = 1'b1; E_MDOp = 4'd4; E_A = 32'd100; E_B = 32'd3;
        @(posedge clk); #1;
        E_MDStart = 1'b0; E_MDOp = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (E_Busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_div busy: got %0b want 1", E_Busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (E_Busy !== 1'b0 || E_RDHI !== 32'd0 || E_RDLO !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_div: got busy=%0b HI=%h LO=%h want 0/0/0", E_Busy,
                     E_RDHI, E_RDLO);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (E_Busy !== 1'b0 || E_RDHI !== 32'd0 || E_RDLO !== 32'd0) begin
            errors++;
            $display("FAIL no_commit: got busy=%0b HI=%h LO=%h want 0/0/0", E_Busy, E_RDHI,
                     E_RDLO);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_write_during_busy();
        test_back_to_back();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_mdu_ctrl.md
# e_mdu_ctrl

Execute-stage multiply/divide scheduler. It owns the HI/LO register pair and sequences multi-cycle `mult`/`multu`/`div`/`divu` operations and single-cycle `mthi`/`mtlo` writes. It exports `E_Busy` to the hazard unit so that later HI/LO-dependent instructions stall. It drives `E_RDHI`/`E_RDLO` into the E-stage HI/LO read mux feeding `mfhi`/`mflo`.

## Interface
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu` (range 1–31).
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu` (range 1–31).
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. `reset`=0 clears all state immediately, independent of `clk`.
- `E_MDStart` input 1: single-cycle start strobe, qualified by `E_MDOp` ∈ {1,2,3,4}.
- `E_MDOp` input 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo. Codes 7–15 are no-ops.
- `E_MDWrite` input 1: `mthi`/`mtlo` write strobe, qualified by `E_MDOp` ∈ {5,6}.
- `E_A` input 32: rs operand (dividend, multiplicand, or `mthi`/`mtlo` data).
- `E_B` input 32: rt operand (divisor or multiplier).
- `E_Busy` output 1: high while an operation is in flight.
- `E_RDHI` output 32: architectural HI register.
- `E_RDLO` output 32: architectural LO register.

## Operation
- **States.** IDLE and RUN, plus a 5-bit down-counter `cnt` and 32-bit pending registers `PHI`/`PLO`.
- **IDLE → RUN.** Taken when `E_MDStart`=1 and `E_MDOp` ∈ {1..4}.
  - Computes the result from `E_A`/`E_B` in that cycle and latches it into `PHI`/`PLO`.
  - Loads `cnt` with `MULT_CYCLES` for ops 1–2, or `DIV_CYCLES` for ops 3–4.
- **RUN.** `cnt` decrements every cycle. When `cnt`=1 on an edge:
  - HI←`PHI`, LO←`PLO`;
  - the next state is IDLE.
- **Arithmetic.**
  - mult: 64-bit signed product → {HI,LO}.
  - multu: 64-bit unsigned product → {HI,LO}.
  - div: signed quotient → LO, remainder → HI, truncating toward zero; the remainder takes the dividend's sign.
  - divu: the unsigned equivalent.
- **Divide by zero** (`E_B`=0, ops 3/4): LO=32'hFFFFFFFF, HI=`E_A`. This is defined behaviour; X must never propagate.
- **Signed overflow** (0x80000000 / 0xFFFFFFFF, op 3): LO=0x80000000, HI=0.
- **mthi/mtlo.** `E_MDWrite`=1 with op 5 writes HI←`E_A`; with op 6 writes LO←`E_A`. The write takes effect at the edge and is accepted only in IDLE.
- **Ignored inputs.**
  - `E_MDStart` or `E_MDWrite` while in RUN is ignored; the hazard unit guarantees this never happens, and the block need not flag it.
  - `E_MDStart` and `E_MDWrite` both high in IDLE: start wins and the write is dropped.
  - Ops 0 and 7–15 cause no state change.
- **Reset.** Asserting `reset` at any time, including mid-RUN, aborts the operation with no commit:
  - state=IDLE, `cnt`=0, `PHI`=`PLO`=0;
  - HI=LO=0, `E_Busy`=0.

## Timing
- **Reset values.** `E_Busy`=0, `E_RDHI`=0, `E_RDLO`=0.
- **Busy window.** If start is sampled at edge T0:
  - `E_Busy`=1 from after T0 through the cycle ending at edge T0+N (N = `MULT_CYCLES` or `DIV_CYCLES`);
  - HI/LO update at edge T0+N, and `E_Busy` falls at that same edge.
- **Start cycle.** `E_Busy` is registered: it is 0 during the start cycle itself. The hazard unit combines `E_MDStart` with `E_Busy`.
- **Result visibility.** `E_RDHI`/`E_RDLO` are registered outputs and show the old values for the whole busy window. The new values appear in the cycle after edge T0+N.
- **Back-to-back.** A new start is accepted in the first cycle after `E_Busy` falls; there are no idle bubbles inside the block.
- **mthi/mtlo latency.** A write at edge T is visible on `E_RDHI`/`E_RDLO` from T onward.
- **N=1.** Busy lasts exactly one cycle and commit happens at T0+1.

## Test plan
- **Reset.** Hold `reset`=0, then release → `E_Busy`=0, HI=LO=0. Assert `reset` mid-div at cycle 4 → HI/LO stay 0 and `E_Busy` drops immediately.
- **mult vs multu.** mult A=0xFFFFFFFF, B=2 → after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFE. Then multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- **Signed div.** div A=0xFFFFFFF9 (−7), B=2 → `E_Busy` high for exactly 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - HI/LO must hold their prior values throughout the busy window.
- **Div corner cases.**
  - divu A=7, B=0 → LO=0xFFFFFFFF, HI=7.
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- **mthi/mtlo.**
  - mthi A=0x12345678 in IDLE → HI=0x12345678 next cycle, LO unchanged.
  - mtlo issued during a mult's busy window → ignored; the final LO equals the mult result.
- **Back-to-back and simultaneous events.**
  - multu 3×4 immediately followed by divu 100/7 in the cycle `E_Busy` falls → LO=12 then LO=14, HI=2; total busy 5+10 cycles with no gap.
  - Start and write asserted in the same IDLE cycle → start executes, write dropped.
